// File: rtl/ldpc_pkg.sv
// Shared constants and FSM state encoding for the LDPC PI-matrix encoder stage.
package ldpc_pkg;

  localparam int CodeLen     = 256;
  localparam int ChkLen      = 128;
  localparam int ChkLen_bits = 7;
  localparam int InfoLen     = CodeLen - ChkLen;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    ACC   = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } enc_state_e;

endpackage

// File: rtl/gf2_dot.sv
// GF(2) inner product: XOR reduction of the bitwise AND of two vectors.
module gf2_dot #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         y
);

  assign y = ^(a & b);

endmodule

// File: rtl/ldpc_pi_encoder.sv
// Systematic LDPC encoder: requests the PI-matrix stream, folds each row into one
// parity bit against the latched info word and emits {info, parity}.
module ldpc_pi_encoder
  import ldpc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               info_valid,
  output logic               info_ready,
  input  logic [InfoLen-1:0] info_in,
  output logic               encoder_read_PI_matrix,
  input  logic               PI_read_receive,
  input  logic               PI_valid,
  input  logic [CodeLen-1:0] dout_PI,
  output logic               code_valid,
  output logic [CodeLen-1:0] code_out,
  output logic               busy
);

  localparam logic [ChkLen_bits-1:0] LastRow = ChkLen_bits'(ChkLen - 1);
  localparam logic [ChkLen_bits-1:0] RowOne  = ChkLen_bits'(1);

  enc_state_e             state_q, state_d;
  logic [InfoLen-1:0]     info_q, info_d;
  logic [ChkLen-1:0]      parity_q, parity_d;
  logic [ChkLen_bits-1:0] row_cnt_q, row_cnt_d;
  logic                   req_q, req_d;
  logic                   info_ready_q, info_ready_d;
  logic                   busy_q, busy_d;
  logic                   code_valid_q, code_valid_d;
  logic [CodeLen-1:0]     code_out_q, code_out_d;
  logic                   row_bit_s;
  logic                   unused_s;

  // The upper half of each PI row is never used by this stage.
  assign unused_s = ^dout_PI[CodeLen-1:InfoLen];

  gf2_dot #(.W(InfoLen)) u_dot (
    .a (dout_PI[InfoLen-1:0]),
    .b (info_q),
    .y (row_bit_s)
  );

  // Next-state and next-output logic for the encoder FSM.
  always_comb begin
    state_d      = state_q;
    info_d       = info_q;
    parity_d     = parity_q;
    row_cnt_d    = row_cnt_q;
    req_d        = req_q;
    info_ready_d = info_ready_q;
    busy_d       = busy_q;
    code_valid_d = 1'b0;
    code_out_d   = code_out_q;
    case (state_q)
      IDLE: begin
        if (info_valid && info_ready_q) begin
          info_d       = info_in;
          parity_d     = {ChkLen{1'b0}};
          row_cnt_d    = {ChkLen_bits{1'b0}};
          req_d        = 1'b1;
          info_ready_d = 1'b0;
          busy_d       = 1'b1;
          state_d      = REQ;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        // A beat coinciding with the acknowledge is deliberately dropped.
        if (PI_read_receive) begin
          req_d   = 1'b0;
          state_d = ACC;
        end else begin
          state_d = REQ;
        end
      end
      ACC: begin
        if (PI_valid) begin
          parity_d[row_cnt_q] = row_bit_s;
          row_cnt_d           = row_cnt_q + RowOne;
          if (row_cnt_q == LastRow) begin
            state_d = DONE;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      DONE: begin
        code_out_d   = {info_q, parity_q};
        code_valid_d = 1'b1;
        state_d      = DRAIN;
      end
      DRAIN: begin
        // Trailing duplicate rows are swallowed here without touching parity.
        if (PI_valid) begin
          state_d = DRAIN;
        end else begin
          info_ready_d = 1'b1;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        req_d        = 1'b0;
        info_ready_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      info_q       <= {InfoLen{1'b0}};
      parity_q     <= {ChkLen{1'b0}};
      row_cnt_q    <= {ChkLen_bits{1'b0}};
      req_q        <= 1'b0;
      info_ready_q <= 1'b1;
      busy_q       <= 1'b0;
      code_valid_q <= 1'b0;
      code_out_q   <= {CodeLen{1'b0}};
    end else begin
      state_q      <= state_d;
      info_q       <= info_d;
      parity_q     <= parity_d;
      row_cnt_q    <= row_cnt_d;
      req_q        <= req_d;
      info_ready_q <= info_ready_d;
      busy_q       <= busy_d;
      code_valid_q <= code_valid_d;
      code_out_q   <= code_out_d;
    end
  end

  assign info_ready             = info_ready_q;
  assign encoder_read_PI_matrix = req_q;
  assign code_valid             = code_valid_q;
  assign code_out               = code_out_q;
  assign busy                   = busy_q;

endmodule

// File: tb/tb_ldpc_pi_encoder.sv
// Directed/randomized bench for ldpc_pi_encoder with a popcount-parity reference model.
module tb_ldpc_pi_encoder;
  import ldpc_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               info_valid = 1'b0;
  logic               info_ready;
  logic [InfoLen-1:0] info_in = '0;
  logic               encoder_read_PI_matrix;
  logic               PI_read_receive = 1'b0;
  logic               PI_valid = 1'b0;
  logic [CodeLen-1:0] dout_PI = '0;
  logic               code_valid;
  logic [CodeLen-1:0] code_out;
  logic               busy;

  int checks = 0;
  int errors = 0;
  int cv_pulses = 0;
  bit ready_leak = 1'b0;
  logic [InfoLen-1:0] rows [ChkLen];

  ldpc_pi_encoder dut (
    .clk(clk), .rst(rst), .info_valid(info_valid), .info_ready(info_ready),
    .info_in(info_in), .encoder_read_PI_matrix(encoder_read_PI_matrix),
    .PI_read_receive(PI_read_receive), .PI_valid(PI_valid), .dout_PI(dout_PI),
    .code_valid(code_valid), .code_out(code_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [CodeLen-1:0] obs, input logic [CodeLen-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Reference: parity bit r is the parity of the popcount of (row r AND info).
  function automatic logic [CodeLen-1:0] model(input logic [InfoLen-1:0] info);
    logic [ChkLen-1:0] p;
    for (int r = 0; r < ChkLen; r++) p[r] = ($countones(rows[r] & info) % 2) == 1;
    return {info, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (code_valid === 1'b1) cv_pulses++;
  endtask

  task automatic start_word(input logic [InfoLen-1:0] w);
    int n;
    n = 0;
    info_valid = 1'b1;
    info_in = w;
    while (info_ready !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    chk_bit("ready_wait", info_ready, 1'b1);
    tick();
    info_valid = 1'b0;
    chk_bit("req_up", encoder_read_PI_matrix, 1'b1);
    chk_bit("busy_up", busy, 1'b1);
    chk_bit("ready_down", info_ready, 1'b0);
  endtask

  task automatic do_ack(input int delay);
    bit dropped;
    dropped = 1'b0;
    for (int i = 0; i < delay; i++) begin
      PI_valid = 1'($urandom_range(0, 1));
      dout_PI = {rand128(), rand128()};
      tick();
      if (encoder_read_PI_matrix !== 1'b1) dropped = 1'b1;
    end
    chk_bit("req_held", dropped, 1'b0);
    PI_valid = 1'b0;
    PI_read_receive = 1'b1;
    tick();
    PI_read_receive = 1'b0;
    chk_bit("req_down", encoder_read_PI_matrix, 1'b0);
  endtask

  task automatic stream(input int first, input int last, input bit gaps);
    for (int r = first; r <= last; r++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
          PI_valid = 1'b0;
          dout_PI = {rand128(), rand128()};
          tick();
        end
      end
      PI_valid = 1'b1;
      dout_PI = {rand128(), rows[r]};
      tick();
      if (info_ready === 1'b1) ready_leak = 1'b1;
    end
  endtask

  // Called right after the last counted beat; checks the pulse, drain and return to IDLE.
  task automatic finish(input int dups, input logic [CodeLen-1:0] exp, output logic [CodeLen-1:0] got);
    int k;
    int p0;
    p0 = cv_pulses;
    chk_bit("cv_early", code_valid, 1'b0);
    k = 0;
    do begin
      PI_valid = (k < dups);
      dout_PI = {rand128(), rand128()};
      tick();
      if (k == 0) begin
        chk_bit("cv_pulse", code_valid, 1'b1);
        chk_vec("code", code_out, exp);
      end
      if (k == 1) chk_bit("cv_single", code_valid, 1'b0);
      k++;
    end while (info_ready !== 1'b1 && k < 60);
    PI_valid = 1'b0;
    chk_int("drain_len", k, (dups < 2) ? 2 : dups + 1);
    chk_bit("busy_idle", busy, 1'b0);
    chk_vec("code_hold", code_out, exp);
    chk_int("pulse_cnt", cv_pulses - p0, 1);
    got = code_out;
  endtask

  task automatic xfer(input logic [InfoLen-1:0] w, input bit gaps, input int delay,
                      input int dups, output logic [CodeLen-1:0] got);
    start_word(w);
    do_ack(delay);
    stream(0, ChkLen - 1, gaps);
    finish(dups, model(w), got);
  endtask

  initial begin
    logic [CodeLen-1:0] got, ref_run, expc;
    logic [InfoLen-1:0] w1, w2;
    int p0;

    // Reset state
    repeat (3) tick();
    chk_bit("rst_ready", info_ready, 1'b1);
    chk_bit("rst_req", encoder_read_PI_matrix, 1'b0);
    chk_bit("rst_cv", code_valid, 1'b0);
    chk_vec("rst_code", code_out, '0);
    chk_bit("rst_busy", busy, 1'b0);
    rst = 1'b1;
    PI_valid = 1'b1;
    PI_read_receive = 1'b1;
    repeat (3) tick();
    PI_valid = 1'b0;
    PI_read_receive = 1'b0;
    chk_bit("idle_ignore_busy", busy, 1'b0);

    // Zero info with random rows
    for (int r = 0; r < ChkLen; r++) rows[r] = rand128();
    xfer('0, 1'b0, 0, 0, got);
    chk_vec("zero_code", got, '0);

    // Identity rows: parity equals info
    for (int r = 0; r < ChkLen; r++) rows[r] = 128'(1) << r;
    w1 = {16{8'hA5}};
    xfer(w1, 1'b0, 1, 1, got);
    expc = {w1, w1};
    chk_vec("ident_const", got, expc);

    // Dense rows with trailing duplicates
    for (int r = 0; r < ChkLen; r++) rows[r] = '1;
    xfer(128'h1, 1'b0, 0, 3, got);
    expc = {128'h1, {ChkLen{1'b1}}};
    chk_vec("dense_pop1", got, expc);
    w1 = (128'h1 << 7) | (128'h1 << 100);
    xfer(w1, 1'b0, 0, 2, got);
    expc = {w1, {ChkLen{1'b0}}};
    chk_vec("dense_pop2", got, expc);

    // Gapless vs gappy run with delayed ack on the same rows and info
    for (int r = 0; r < ChkLen; r++) rows[r] = rand128();
    w1 = rand128();
    xfer(w1, 1'b0, 0, 0, ref_run);
    xfer(w1, 1'b1, 5, 1, got);
    chk_vec("gappy_same", got, ref_run);

    // Reset in the middle of accumulation
    w1 = rand128();
    start_word(w1);
    do_ack(0);
    stream(0, 59, 1'b0);
    PI_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk_bit("mid_rst_ready", info_ready, 1'b1);
    chk_bit("mid_rst_req", encoder_read_PI_matrix, 1'b0);
    chk_bit("mid_rst_cv", code_valid, 1'b0);
    chk_vec("mid_rst_code", code_out, '0);
    chk_bit("mid_rst_busy", busy, 1'b0);
    tick();
    rst = 1'b1;
    p0 = cv_pulses;
    PI_read_receive = 1'b1;
    stream(60, ChkLen - 1, 1'b0);
    PI_valid = 1'b0;
    PI_read_receive = 1'b0;
    tick();
    chk_bit("post_rst_busy", busy, 1'b0);
    chk_bit("post_rst_req", encoder_read_PI_matrix, 1'b0);
    chk_int("post_rst_pulses", cv_pulses - p0, 0);
    w2 = rand128();
    xfer(w2, 1'b0, 2, 0, got);

    // Back-to-back: second word held during the first transfer
    for (int r = 0; r < ChkLen; r++) rows[r] = rand128();
    w1 = rand128();
    w2 = rand128();
    p0 = cv_pulses;
    start_word(w1);
    info_valid = 1'b1;
    info_in = w2;
    ready_leak = 1'b0;
    do_ack(0);
    stream(0, ChkLen - 1, 1'b1);
    finish(1, model(w1), got);
    chk_bit("b2b_ready_low", ready_leak, 1'b0);
    tick();
    info_valid = 1'b0;
    chk_bit("b2b_accept", encoder_read_PI_matrix, 1'b1);
    do_ack(0);
    stream(0, ChkLen - 1, 1'b0);
    finish(0, model(w2), got);
    chk_int("b2b_pulses", cv_pulses - p0, 2);

    // Random transfers
    for (int t = 0; t < 3; t++) begin
      for (int r = 0; r < ChkLen; r++) rows[r] = rand128();
      xfer(rand128(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
           int'($urandom_range(0, 3)), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
